outport_arbiter: RTL

Output-port scheduler for the hexa router. One instance sits in front of each output port. It arbitrates the `port_rqs` bits raised by the five inports with a round-robin policy and returns `arb_ack` to the winner. It then sequences the packet's flits through the crossbar under downstream credit flow control, holding the crossbar select until the last flit has left.

---
 rtl/hexa_pkg.sv | 23 ++
 rtl/rr_picker.sv | 32 +++
 rtl/outport_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hexa_pkg.sv
// Shared definitions for the hexa router: port count, port encoding,
// crossbar select width and the output-arbiter FSM encoding.
package hexa_pkg;

  localparam int PORTS = 5;
  localparam int SEL_W = 3;

  // Inport index encoding used by xbar_sel and the req/ack vectors
  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_N     = 3'd1,
    PORT_E     = 3'd2,
    PORT_S     = 3'd3,
    PORT_W     = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set req bit at or after rr_ptr, wrapping
// modulo PORTS. Purely combinational.
module rr_picker #(
  parameter int PORTS = 5,
  parameter int SEL_W = 3
) (
  input  logic [PORTS-1:0] req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [PORTS-1:0] gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Scan PORTS positions starting at rr_ptr; the first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = SEL_W'((int'(rr_ptr) + k) % PORTS);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/outport_arbiter.sv
// Output-port scheduler: round-robin grant, then issues the packet's flits
// through the crossbar under downstream credit flow control.
// xfer_en is high in exactly the cycles a flit is issued; the credit
// counter is charged at the end of those cycles, so the issue decision for
// the next cycle subtracts the flit currently in flight.
module outport_arbiter #(
  parameter int PORTS         = hexa_pkg::PORTS,
  parameter int FLITS_PER_PKT = 4,
  parameter int CREDITS       = 4,
  parameter int SEL_W         = hexa_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req,
  input  logic             credit_in,
  output logic [PORTS-1:0] arb_ack,
  output logic [PORTS-1:0] xfer_en,
  output logic [SEL_W-1:0] xbar_sel,
  output logic             out_valid,
  output logic             busy,
  output logic             crd_err
);

  import hexa_pkg::*;

  localparam int CW = $clog2(CREDITS + 1);
  localparam int FW = (FLITS_PER_PKT > 1) ? $clog2(FLITS_PER_PKT) : 1;

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] rr_ptr, rr_d;
  logic [FW-1:0]    flit_cnt, flit_d;
  logic [CW-1:0]    credit_cnt;
  logic [PORTS-1:0] ack_d, xen_d;
  logic [SEL_W-1:0] sel_d;
  logic [PORTS-1:0] pick_gnt;
  logic [SEL_W-1:0] pick_idx;
  logic             avail;
  logic             last_flit;

  rr_picker #(.PORTS(PORTS), .SEL_W(SEL_W)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // Credit left for the next cycle once the flit issuing now is charged
  assign avail     = credit_cnt > CW'(out_valid);
  assign last_flit = out_valid && (flit_cnt == FW'(FLITS_PER_PKT - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and next registered-output values
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel_d   = xbar_sel;
    rr_d    = rr_ptr;
    flit_d  = flit_cnt;
    ack_d   = '0;
    xen_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_ACK;
          owner_d = pick_idx;
          sel_d   = pick_idx;
          ack_d   = pick_gnt;
        end
      end
      ST_ACK: begin
        state_d = ST_XFER;
        flit_d  = '0;
        if (avail) xen_d = PORTS'(1) << owner_q;
      end
      ST_XFER: begin
        if (out_valid) flit_d = flit_cnt + 1'b1;
        if (last_flit) begin
          state_d = ST_IDLE;
          rr_d    = (owner_q == SEL_W'(PORTS - 1)) ? '0 : owner_q + 1'b1;
        end else if (avail) begin
          xen_d = PORTS'(1) << owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= '0;
      rr_ptr    <= '0;
      flit_cnt  <= '0;
      arb_ack   <= '0;
      xfer_en   <= '0;
      xbar_sel  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      rr_ptr    <= rr_d;
      flit_cnt  <= flit_d;
      arb_ack   <= ack_d;
      xfer_en   <= xen_d;
      xbar_sel  <= sel_d;
      out_valid <= |xen_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Credit counter: issue consumes, credit_in returns; overflow is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CW'(CREDITS);
      crd_err    <= 1'b0;
    end else if (out_valid && !credit_in) begin
      credit_cnt <= credit_cnt - 1'b1;
    end else if (credit_in && !out_valid) begin
      if (credit_cnt == CW'(CREDITS)) crd_err    <= 1'b1;
      else                            credit_cnt <= credit_cnt + 1'b1;
    end
  end

endmodule
